// File: rtl/accu_rr_sched.sv
// Shared-adder accumulator: round-robin grants one sample per cycle into a per-requester
// running sum; a last sample emits the frame sum on a valid/ready result port.
module accu_rr_sched #(
  parameter  int unsigned N   = 4,
  parameter  int unsigned W   = 16,
  parameter  int unsigned AW  = 24,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_sum,
  output logic [IDW-1:0] out_id
);

  logic [AW-1:0]  ctx [N];
  logic [IDW-1:0] ptr;

  logic           free_c;
  logic [N-1:0]   elig_c;
  logic [N-1:0]   grant_c;
  logic           gnt_any_c;
  logic [IDW-1:0] gnt_idx_c;
  logic [W-1:0]   gnt_data_c;
  logic           gnt_last_c;
  logic [AW-1:0]  nxt_c;

  // Last samples need a free result slot; non-last samples never wait on the consumer.
  always_comb begin
    free_c = !out_valid || out_ready;
    elig_c = req_valid & (~req_last | {N{free_c}});
  end

  // Cyclic priority search starting just after the previous winner.
  always_comb begin
    int unsigned j;
    grant_c   = '0;
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    j         = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!gnt_any_c && elig_c[j]) begin
        gnt_any_c  = 1'b1;
        gnt_idx_c  = IDW'(j);
        grant_c[j] = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_data_c = req_data[32'(gnt_idx_c)*W +: W];
    gnt_last_c = req_last[gnt_idx_c];
    nxt_c      = ctx[gnt_idx_c] + AW'(gnt_data_c);
    req_ready  = rst ? '0 : grant_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) ctx[i] <= '0;
      ptr       <= IDW'(N - 1);
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_id    <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (gnt_any_c) begin
        ptr <= gnt_idx_c;
        if (gnt_last_c) begin
          ctx[gnt_idx_c] <= '0;
          out_sum        <= nxt_c;
          out_id         <= gnt_idx_c;
          out_valid      <= 1'b1;
        end else begin
          ctx[gnt_idx_c] <= nxt_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_accu_rr_sched.sv
// Directed and randomized checks of accu_rr_sched: arbitration order, backpressure,
// wrap, reset, and a scoreboard of frame sums.
module tb_accu_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [63:0] req_data;
  logic        out_ready;

  logic [3:0]  req_ready;
  logic        out_valid;
  logic [23:0] out_sum;
  logic [1:0]  out_id;

  logic [3:0]  req_ready16;
  logic        out_valid16;
  logic [15:0] out_sum16;
  logic [1:0]  out_id16;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [23:0] sum;
  } res_t;

  res_t        exp_q[$];
  logic [23:0] ctx_m [4];
  logic [1:0]  ptr_m;
  logic        ov_m;
  logic [3:0]  hold;

  always #5 clk = ~clk;

  accu_rr_sched #(.N(4), .W(16), .AW(24)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id)
  );

  // Narrow-accumulator instance sharing all inputs, used for the wrap case.
  accu_rr_sched #(.N(4), .W(16), .AW(16)) dut16 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready16), .out_valid(out_valid16), .out_ready(out_ready),
    .out_sum(out_sum16), .out_id(out_id16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [15:0] d);
    req_valid[i]       = v;
    req_last[i]        = l;
    req_data[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic        free_m;
    logic        found;
    logic [1:0]  gi;
    logic [1:0]  j;
    logic [23:0] s;
    logic        v;
    res_t        r;

    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;

    // Reset state; ready forced low while reset is asserted
    req_valid = 4'hF;
    #1 check("rst_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    step();
    step();
    check("rst_ovalid", 32'(out_valid), 32'h0);
    check("rst_sum", 32'(out_sum), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);
    rst = 1'b0;

    // T1: single frame 1+2+3+4 on requester 0
    for (int k = 1; k <= 4; k++) begin
      set_req(0, 1'b1, k == 4, 16'(k));
      #1 check("t1_ready", 32'(req_ready), 32'h1);
      check("t1_ovalid_low", 32'(out_valid), 32'h0);
      step();
    end
    req_valid = '0;
    check("t1_ovalid", 32'(out_valid), 32'h1);
    check("t1_sum", 32'(out_sum), 32'd10);
    check("t1_id", 32'(out_id), 32'h0);
    step();
    check("t1_ovalid_fall", 32'(out_valid), 32'h0);

    // T2: fairness with all requesters continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 16'h1);
    for (int c = 0; c < 8; c++) begin
      #1 check("t2_grant", 32'(req_ready), 32'(1 << (c % 4)));
      step();
    end
    req_valid = '0;

    // T3: backpressure blocks last samples only
    do_reset();
    out_ready = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'd5);
    #1 check("t3_g0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("t3_pend_valid", 32'(out_valid), 32'h1);
    check("t3_pend_sum", 32'(out_sum), 32'd5);
    set_req(1, 1'b1, 1'b1, 16'd7);
    set_req(2, 1'b1, 1'b0, 16'd9);
    #1 check("t3_nonlast_pass", 32'(req_ready), 32'h4);
    step();
    req_valid[2] = 1'b0;
    #1 check("t3_last_blocked", 32'(req_ready), 32'h0);
    step();
    check("t3_hold_valid", 32'(out_valid), 32'h1);
    check("t3_hold_sum", 32'(out_sum), 32'd5);
    check("t3_hold_id", 32'(out_id), 32'h0);
    out_ready = 1'b1;
    #1 check("t3_g1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check("t3_new_valid", 32'(out_valid), 32'h1);
    check("t3_new_sum", 32'(out_sum), 32'd7);
    check("t3_new_id", 32'(out_id), 32'h1);
    set_req(2, 1'b1, 1'b1, 16'd1);
    #1 check("t3_g2", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    check("t3_b2b_valid", 32'(out_valid), 32'h1);
    check("t3_b2b_sum", 32'(out_sum), 32'd10);
    check("t3_b2b_id", 32'(out_id), 32'h2);
    step();
    check("t3_drain", 32'(out_valid), 32'h0);

    // T4: wrap modulo 2^AW
    do_reset();
    set_req(2, 1'b1, 1'b0, 16'hFFFF);
    step();
    set_req(2, 1'b1, 1'b1, 16'h0002);
    #1 check("t4_ready16", 32'(req_ready16), 32'h4);
    step();
    req_valid = '0;
    check("t4_valid16", 32'(out_valid16), 32'h1);
    check("t4_sum16", 32'(out_sum16), 32'h0001);
    check("t4_id16", 32'(out_id16), 32'h2);
    check("t4_sum24", 32'(out_sum), 32'h10001);
    step();

    // T5: reset mid-frame discards partials and a pending result
    do_reset();
    out_ready = 1'b0;
    set_req(1, 1'b1, 1'b1, 16'd3);
    step();
    req_valid = '0;
    set_req(3, 1'b1, 1'b0, 16'd5);
    step();
    set_req(3, 1'b1, 1'b0, 16'd6);
    step();
    check("t5_pending", 32'(out_valid), 32'h1);
    do_reset();
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    set_req(3, 1'b1, 1'b1, 16'd7);
    set_req(0, 1'b1, 1'b0, 16'd0);
    #1 check("t5_prio0", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    #1 check("t5_g3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    check("t5_valid", 32'(out_valid), 32'h1);
    check("t5_sum", 32'(out_sum), 32'd7);
    check("t5_id", 32'(out_id), 32'h3);
    step();

    // T6: random traffic against a reference model and result scoreboard
    do_reset();
    for (int i = 0; i < 4; i++) ctx_m[i] = '0;
    ptr_m = 2'd3;
    ov_m  = 1'b0;
    hold  = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!hold[i]) begin
          v = ($urandom_range(0, 1) == 1);
          set_req(i, v, ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 65535)));
          hold[i] = v;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      free_m = !ov_m || out_ready;
      found  = 1'b0;
      gi     = '0;
      for (int k = 1; k <= 4; k++) begin
        j = 2'((int'(ptr_m) + k) % 4);
        if (!found && req_valid[j] && (!req_last[j] || free_m)) begin
          found = 1'b1;
          gi    = j;
        end
      end
      check("t6_grant", 32'(req_ready), found ? 32'(1 << gi) : 32'h0);
      check("t6_ovalid", 32'(out_valid), 32'(ov_m));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("t6_spurious", 32'h1, 32'h0);
        end else begin
          r = exp_q.pop_front();
          check("t6_id", 32'(out_id), 32'(r.id));
          check("t6_sum", 32'(out_sum), 32'(r.sum));
        end
      end
      if (ov_m && out_ready) ov_m = 1'b0;
      if (found) begin
        ptr_m = gi;
        s     = ctx_m[gi] + 24'(req_data[gi*16 +: 16]);
        if (req_last[gi]) begin
          ctx_m[gi] = '0;
          r.id  = gi;
          r.sum = s;
          exp_q.push_back(r);
          ov_m  = 1'b1;
        end else begin
          ctx_m[gi] = s;
        end
        hold[gi] = 1'b0;
      end
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("t6_drain_spurious", 32'h1, 32'h0);
        end else begin
          r = exp_q.pop_front();
          check("t6_drain_id", 32'(out_id), 32'(r.id));
          check("t6_drain_sum", 32'(out_sum), 32'(r.sum));
        end
      end
      step();
    end
    check("t6_lost", 32'(exp_q.size()), 32'h0);
    check("t6_idle", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
